// File: rtl/wb_pipe.sv
// MEM/WB pipeline register bank of configurable depth. It also provides writeback data
// selection, register forwarding lookup and a saturating stall-cycle counter.
module wb_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALU_rst_i,
    input  logic [DATA_W-1:0] ReadData_i,
    input  logic [RD_W-1:0]   RDaddr_i,
    input  logic [RD_W-1:0]   fwd_addr_i,
    output logic              valid_o,
    output logic              RegWrite_o,
    output logic              MemtoReg_o,
    output logic [DATA_W-1:0] ALU_rst_o,
    output logic [DATA_W-1:0] ReadData_o,
    output logic [RD_W-1:0]   RDaddr_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic              fwd_hit_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    generate
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("wb_pipe: STAGES must be in 1..4");
        end
    endgenerate

    typedef struct packed {
        logic              v;
        logic              rw;
        logic              m2r;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rdata;
        logic [RD_W-1:0]   rd;
    } stage_t;

    stage_t            stage_q [STAGES];
    stage_t            stage_d [STAGES];
    stage_t            in_slot;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0] wb_w   [STAGES];
    logic [STAGES-1:0] hit_w;

    // Register 0 is hardwired, so a write to it is dropped on entry.
    always_comb begin
        in_slot       = '0;
        in_slot.v     = valid_i;
        in_slot.rw    = RegWrite_i & valid_i & (RDaddr_i != '0);
        in_slot.m2r   = MemtoReg_i;
        in_slot.alu   = ALU_rst_i;
        in_slot.rdata = ReadData_i;
        in_slot.rd    = RDaddr_i;
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stage_q[i];
        end
        stall_cnt_d = stall_cnt_q;
        if (start_i && flush_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_d[i].v  = 1'b0;
                stage_d[i].rw = 1'b0;
            end
        end else if (start_i && stall_i) begin
            if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end else if (start_i) begin
            stage_d[0] = in_slot;
            for (int i = 1; i < STAGES; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            assign wb_w[gi]  = stage_q[gi].m2r ? stage_q[gi].rdata : stage_q[gi].alu;
            assign hit_w[gi] = stage_q[gi].v & stage_q[gi].rw &
                               (stage_q[gi].rd == fwd_addr_i) & (fwd_addr_i != '0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching stage overwrites older ones.
    always_comb begin
        fwd_hit_o  = 1'b0;
        fwd_data_o = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            if (hit_w[i]) begin
                fwd_hit_o  = 1'b1;
                fwd_data_o = wb_w[i];
            end
        end
    end

    assign valid_o     = stage_q[STAGES-1].v;
    assign RegWrite_o  = stage_q[STAGES-1].rw & stage_q[STAGES-1].v;
    assign MemtoReg_o  = stage_q[STAGES-1].m2r;
    assign ALU_rst_o   = stage_q[STAGES-1].alu;
    assign ReadData_o  = stage_q[STAGES-1].rdata;
    assign RDaddr_o    = stage_q[STAGES-1].rd;
    assign WBdata_o    = wb_w[STAGES-1];
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: a 1-stage (2-bit counter) and a 3-stage instance share the same stimulus.
// Vector table for the 1-stage instance, queue scoreboard for both, hand sequences for stall/flush/reset.
module tb_wb_pipe;

    logic        clk = 1'b0;
    logic        rst, start, stall, flush, valid, rw, m2r;
    logic [31:0] alu, rdata;
    logic [4:0]  rd, fwd_addr;

    logic        v1, rwo1, m2ro1, hit1;
    logic [31:0] alu1, rdat1, wb1, fwdd1;
    logic [4:0]  rd1;
    logic [1:0]  cnt1_o;

    logic        v3, rwo3, m2ro3, hit3;
    logic [31:0] alu3, rdat3, wb3, fwdd3;
    logic [4:0]  rd3;
    logic [15:0] cnt3_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    always #5 clk = ~clk;

    wb_pipe #(.DATA_W(32), .RD_W(5), .STAGES(1), .CNT_W(2)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .RegWrite_i(rw), .MemtoReg_i(m2r), .ALU_rst_i(alu),
        .ReadData_i(rdata), .RDaddr_i(rd), .fwd_addr_i(fwd_addr),
        .valid_o(v1), .RegWrite_o(rwo1), .MemtoReg_o(m2ro1), .ALU_rst_o(alu1),
        .ReadData_o(rdat1), .RDaddr_o(rd1), .WBdata_o(wb1), .fwd_hit_o(hit1),
        .fwd_data_o(fwdd1), .stall_cnt_o(cnt1_o)
    );

    wb_pipe #(.DATA_W(32), .RD_W(5), .STAGES(3), .CNT_W(16)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .flush_i(flush),
        .valid_i(valid), .RegWrite_i(rw), .MemtoReg_i(m2r), .ALU_rst_i(alu),
        .ReadData_i(rdata), .RDaddr_i(rd), .fwd_addr_i(fwd_addr),
        .valid_o(v3), .RegWrite_o(rwo3), .MemtoReg_o(m2ro3), .ALU_rst_o(alu3),
        .ReadData_o(rdat3), .RDaddr_o(rd3), .WBdata_o(wb3), .fwd_hit_o(hit3),
        .fwd_data_o(fwdd3), .stall_cnt_o(cnt3_o)
    );

    typedef struct packed {
        logic        v;
        logic        rw;
        logic [31:0] wb;
        logic [4:0]  rd;
    } slot_t;

    slot_t q1[$];
    slot_t q3[$];
    int    cnt1_m, cnt3_m;

    typedef struct {
        logic        v, rw, m2r;
        logic [31:0] alu, rdata;
        logic [4:0]  rd;
        logic        exp_rw;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Scoreboard update for one edge, based on the inputs that were applied at that edge.
    task automatic model_edge();
        slot_t s;
        s.v  = valid;
        s.rw = rw & valid & (rd != 5'd0);
        s.wb = m2r ? rdata : alu;
        s.rd = rd;
        if (rst) begin
            q1.delete(); q3.delete();
            q1.push_back('0);
            repeat (3) q3.push_back('0);
            cnt1_m = 0; cnt3_m = 0;
        end else if (start && flush) begin
            foreach (q1[i]) begin q1[i].v = 1'b0; q1[i].rw = 1'b0; end
            foreach (q3[i]) begin q3[i].v = 1'b0; q3[i].rw = 1'b0; end
        end else if (start && stall) begin
            if (cnt1_m < 3) cnt1_m++;
            if (cnt3_m < 65535) cnt3_m++;
        end else if (start) begin
            q1.push_back(s); void'(q1.pop_front());
            q3.push_back(s); void'(q3.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        model_edge();
        chk("v1", 32'(v1), 32'(q1[0].v));
        chk("rw1", 32'(rwo1), 32'(q1[0].rw));
        chk("v3", 32'(v3), 32'(q3[0].v));
        chk("rw3", 32'(rwo3), 32'(q3[0].rw));
        if (q1[0].v) begin
            chk("wb1", wb1, q1[0].wb);
            chk("rd1", 32'(rd1), 32'(q1[0].rd));
        end
        if (q3[0].v) begin
            chk("wb3", wb3, q3[0].wb);
            chk("rd3", 32'(rd3), 32'(q3[0].rd));
        end
        chk("cnt1", 32'(cnt1_o), 32'(cnt1_m));
        chk("cnt3", 32'(cnt3_o), 32'(cnt3_m));
        $display("cycle %0d: in v=%0b rd=%0d | s1 v=%0b rw=%0b rd=%0d wb=%h | s3 v=%0b rw=%0b rd=%0d wb=%h cnt=%0d",
                 cycle, valid, rd, v1, rwo1, rd1, wb1, v3, rwo3, rd3, wb3, cnt3_o);
    endtask

    // Forwarding lookup against the 3-stage scoreboard, youngest entry first.
    task automatic fwd_check(input logic [4:0] a);
        logic        eh;
        logic [31:0] ed;
        fwd_addr = a;
        #1;
        eh = 1'b0; ed = 32'd0;
        for (int i = q3.size() - 1; i >= 0; i--) begin
            if (!eh && q3[i].v && q3[i].rw && q3[i].rd == a && a != 5'd0) begin
                eh = 1'b1; ed = q3[i].wb;
            end
        end
        chk("fwd_hit3", 32'(hit3), 32'(eh));
        chk("fwd_data3", fwdd3, ed);
    endtask

    task automatic drive(input logic v_, input logic rw_, input logic m2r_,
                         input logic [31:0] alu_, input logic [31:0] rd_data_, input logic [4:0] rd_);
        valid = v_; rw = rw_; m2r = m2r_; alu = alu_; rdata = rd_data_; rd = rd_;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 1'b1, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0011, 32'h0000_0099, 5'd7, 1'b1, 32'h0000_0011};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0022, 32'h0000_0098, 5'd8, 1'b1, 32'h0000_0022};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0033, 32'h0000_0000, 5'd9, 1'b0, 32'h0000_0033};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0055, 5'd0, 1'b0, 32'h0000_0055};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0066, 32'h0000_0077, 5'd3, 1'b0, 32'h0000_0077};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_000A, 32'h0000_0000, 5'd9, 1'b1, 32'h0000_000A};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h0000_000B, 32'h0000_0000, 5'd9, 1'b1, 32'h0000_000B};

        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; fwd_addr = 5'd0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        step();
        step();
        chk("rst_wb1", wb1, 32'd0);
        chk("rst_wb3", wb3, 32'd0);
        fwd_check(5'd5);
        chk("rst_hit3_const", 32'(hit3), 32'd0);

        rst = 1'b0; start = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].alu, vecs[i].rdata, vecs[i].rd);
            step();
            chk("vec_v1", 32'(v1), 32'(vecs[i].v));
            chk("vec_rw1", 32'(rwo1), 32'(vecs[i].exp_rw));
            chk("vec_wb1", wb1, vecs[i].exp_wb);
            chk("vec_rd1", 32'(rd1), 32'(vecs[i].rd));
            if (i == 1) begin
                fwd_addr = 5'd7; #1;
                chk("fwd7_hit", 32'(hit3), 32'd1);
                chk("fwd7_data", fwdd3, 32'h11);
            end
            if (i == 3) begin
                chk("lat3_rd7", 32'(rd3), 32'd7);
                chk("lat3_wb7", wb3, 32'h11);
            end
            if (i == 4) begin
                chk("lat3_rd8", 32'(rd3), 32'd8);
                chk("lat3_wb8", wb3, 32'h22);
                fwd_check(5'd0);
                chk("fwd0_hit", 32'(hit3), 32'd0);
            end
            fwd_check(vecs[i].rd);
        end
        fwd_addr = 5'd9; #1;
        chk("fwd9_young_hit", 32'(hit3), 32'd1);
        chk("fwd9_young_data", fwdd3, 32'hB);

        // Stall with new garbage on the inputs: everything must stay frozen.
        stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'hBAD0_0000, 32'hBAD1_1111, 5'd12);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_rd3", 32'(rd3), 32'd3);
            chk("stall_wb3", wb3, 32'h77);
            chk("stall_rd1", 32'(rd1), 32'd9);
        end
        chk("stall4_cnt3", 32'(cnt3_o), 32'd4);
        chk("stall4_cnt1_sat", 32'(cnt1_o), 32'd3);
        step();
        chk("stall5_cnt1_sat", 32'(cnt1_o), 32'd3);
        chk("stall5_cnt3", 32'(cnt3_o), 32'd5);

        flush = 1'b1;
        step();
        chk("flush_v3", 32'(v3), 32'd0);
        chk("flush_rw3", 32'(rwo3), 32'd0);
        chk("flush_v1", 32'(v1), 32'd0);
        fwd_check(5'd9);
        chk("flush_hit3", 32'(hit3), 32'd0);
        chk("flush_cnt3", 32'(cnt3_o), 32'd5);

        // start low: no counting, no advance.
        flush = 1'b0; start = 1'b0;
        step();
        stall = 1'b0;
        step();
        chk("idle_cnt3", 32'(cnt3_o), 32'd5);
        chk("idle_v1", 32'(v1), 32'd0);

        // Reset in the middle of a stall.
        start = 1'b1; stall = 1'b1; rst = 1'b1;
        step();
        chk("rst_cnt1", 32'(cnt1_o), 32'd0);
        chk("rst_cnt3", 32'(cnt3_o), 32'd0);
        chk("rst_v1", 32'(v1), 32'd0);
        chk("rst_wb1b", wb1, 32'd0);

        rst = 1'b0; stall = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_005A, 32'h0, 5'd9);
        step();
        chk("post_rst_wb1", wb1, 32'h5A);
        chk("post_rst_rw1", 32'(rwo1), 32'd1);
        fwd_check(5'd9);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
